// File: rtl/spu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spu_pkg
//  Description : Shared definitions for the writeback / forwarding pipe:
//                register-file geometry, default pipe depth, the writeback
//                entry record and the readiness rule for in-flight results.
//  Revision    : 1.0  initial release
// ============================================================================
package spu_pkg;

  localparam int ADDR_W   = 7;    // 128 architectural registers
  localparam int DATA_W   = 128;  // register width
  localparam int WB_DEPTH = 7;    // writeback stages per pipe
  localparam int LAT_W    = 3;    // width of the forwardable-stage field
  localparam int NUM_RD   = 6;    // operand read ports

  // One writeback stage slot.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [LAT_W-1:0]  lat;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // A result sitting in 1-based stage 'stage' can be forwarded once the
  // stage index reaches its latency; latency 0 behaves like latency 1.
  function automatic logic is_ready(input int stage, input logic [LAT_W-1:0] lat);
    int eff;
    eff = (lat == '0) ? 1 : int'(lat);
    return (stage >= eff);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_lane.sv
`default_nettype none
// ============================================================================
//  Module      : wb_lane
//  Description : One execution pipe's writeback shift register. Stage 1
//                (index 0) captures the injected result; every entry moves
//                one stage per cycle. A flush kills stage 1..DEPTH-1
//                contents and the same-cycle injection; the stage-DEPTH
//                entry leaves the lane anyway, so it still commits.
//  Ports       : clk      clock
//                rst      synchronous active-high reset (clears valids)
//                i_flush  kill all not-yet-committed results
//                i_inj    entry injected this cycle
//                o_stage  current contents, index 0 = stage 1
//  Revision    : 1.0  initial release
// ============================================================================
module wb_lane
  import spu_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH   // must be >= 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_flush,
  input  wb_entry_t i_inj,
  output wb_entry_t o_stage [DEPTH]
);

  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [LAT_W-1:0]  r_lat  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];

  // Only the valid bits carry reset; the payload is qualified by them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      r_valid <= {r_valid[DEPTH-2:0], i_inj.valid} & {DEPTH{~i_flush}};
    end
  end

  always_ff @(posedge clk) begin
    r_addr[0] <= i_inj.addr;
    r_lat[0]  <= i_inj.lat;
    r_data[0] <= i_inj.data;
    for (int i = 1; i < DEPTH; i++) begin
      r_addr[i] <= r_addr[i-1];
      r_lat[i]  <= r_lat[i-1];
      r_data[i] <= r_data[i-1];
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      o_stage[i].valid = r_valid[i];
      o_stage[i].addr  = r_addr[i];
      o_stage[i].lat   = r_lat[i];
      o_stage[i].data  = r_data[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_fwd_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fwd_pipe
//  Description : Dual (even/odd) writeback pipe with result forwarding.
//                Each pipe is a wb_lane; the stage-DEPTH entries drive the
//                register-file write ports. Six operand addresses are
//                matched against all in-flight results; the youngest match
//                (lowest stage, odd before even inside a stage) is
//                forwarded if ready, otherwise fwd_stall is raised.
//  Config      : WB_FWD_EN  defined   -> forwarding enabled
//                           undefined -> no forwarding; stall on any match
//                                        in stages 1..DEPTH-1
//  Ports       : clk, rst (sync, active high)
//                even_* / odd_*  : valid, addr, data, lat of injected result
//                flush           : kill not-yet-committed results
//                rd_addr_1..6    : operand addresses
//                fwd_hit_1..6, fwd_data_1..6, fwd_stall : forwarding results
//                reg_write_en/addr/data_1 (even), _2 (odd) : commit ports
//  Revision    : 1.0  initial release
// ============================================================================
module wb_fwd_pipe
  import spu_pkg::wb_entry_t;
#(
  parameter int DEPTH  = spu_pkg::WB_DEPTH,
  parameter int ADDR_W = spu_pkg::ADDR_W,   // must match spu_pkg
  parameter int DATA_W = spu_pkg::DATA_W    // must match spu_pkg
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              even_valid,
  input  logic [ADDR_W-1:0] even_addr,
  input  logic [DATA_W-1:0] even_data,
  input  logic [2:0]        even_lat,
  input  logic              odd_valid,
  input  logic [ADDR_W-1:0] odd_addr,
  input  logic [DATA_W-1:0] odd_data,
  input  logic [2:0]        odd_lat,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  input  logic [ADDR_W-1:0] rd_addr_3,
  input  logic [ADDR_W-1:0] rd_addr_4,
  input  logic [ADDR_W-1:0] rd_addr_5,
  input  logic [ADDR_W-1:0] rd_addr_6,
  output logic              fwd_hit_1,
  output logic              fwd_hit_2,
  output logic              fwd_hit_3,
  output logic              fwd_hit_4,
  output logic              fwd_hit_5,
  output logic              fwd_hit_6,
  output logic [DATA_W-1:0] fwd_data_1,
  output logic [DATA_W-1:0] fwd_data_2,
  output logic [DATA_W-1:0] fwd_data_3,
  output logic [DATA_W-1:0] fwd_data_4,
  output logic [DATA_W-1:0] fwd_data_5,
  output logic [DATA_W-1:0] fwd_data_6,
  output logic              fwd_stall,
  output logic              reg_write_en_1,
  output logic [ADDR_W-1:0] reg_write_addr_1,
  output logic [DATA_W-1:0] reg_write_data_1,
  output logic              reg_write_en_2,
  output logic [ADDR_W-1:0] reg_write_addr_2,
  output logic [DATA_W-1:0] reg_write_data_2
);

  localparam int NRD = spu_pkg::NUM_RD;

  // The entry record has package-fixed widths.
  if (ADDR_W != spu_pkg::ADDR_W || DATA_W != spu_pkg::DATA_W) begin : g_width_check
    $error("wb_fwd_pipe: ADDR_W/DATA_W must equal the spu_pkg values");
  end

  wb_entry_t w_even_inj;
  wb_entry_t w_odd_inj;
  wb_entry_t w_even [DEPTH];
  wb_entry_t w_odd  [DEPTH];

  assign w_even_inj = '{valid: even_valid, addr: even_addr, lat: even_lat, data: even_data};
  assign w_odd_inj  = '{valid: odd_valid,  addr: odd_addr,  lat: odd_lat,  data: odd_data};

  wb_lane #(.DEPTH(DEPTH)) u_even_lane (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .i_inj   (w_even_inj),
    .o_stage (w_even)
  );

  wb_lane #(.DEPTH(DEPTH)) u_odd_lane (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .i_inj   (w_odd_inj),
    .o_stage (w_odd)
  );

  // ---------------------------------------------------------------- commit
  // Same-address commits: odd is younger, so only its value is written.
  // Nothing is written while rst is asserted.
  logic w_same_addr;
  assign w_same_addr = w_even[DEPTH-1].valid && w_odd[DEPTH-1].valid &&
                       (w_even[DEPTH-1].addr == w_odd[DEPTH-1].addr);

  assign reg_write_en_1   = ~rst & w_even[DEPTH-1].valid & ~w_same_addr;
  assign reg_write_addr_1 = reg_write_en_1 ? w_even[DEPTH-1].addr : '0;
  assign reg_write_data_1 = reg_write_en_1 ? w_even[DEPTH-1].data : '0;
  assign reg_write_en_2   = ~rst & w_odd[DEPTH-1].valid;
  assign reg_write_addr_2 = reg_write_en_2 ? w_odd[DEPTH-1].addr : '0;
  assign reg_write_data_2 = reg_write_en_2 ? w_odd[DEPTH-1].data : '0;

  // ------------------------------------------------------------ forwarding
  logic [ADDR_W-1:0] w_rd_addr [NRD];
  logic [NRD-1:0]    w_hit;
  logic [DATA_W-1:0] w_fdata [NRD];
  logic [NRD-1:0]    w_pend;

  assign w_rd_addr[0] = rd_addr_1;
  assign w_rd_addr[1] = rd_addr_2;
  assign w_rd_addr[2] = rd_addr_3;
  assign w_rd_addr[3] = rd_addr_4;
  assign w_rd_addr[4] = rd_addr_5;
  assign w_rd_addr[5] = rd_addr_6;

`ifdef WB_FWD_EN
  always_comb begin
    logic              w_found;
    logic              w_rdy;
    logic [DATA_W-1:0] w_win;
    w_hit   = '0;
    w_pend  = '0;
    w_fdata = '{default: '0};
    for (int k = 0; k < NRD; k++) begin
      w_found = 1'b0;
      w_rdy   = 1'b0;
      w_win   = '0;
      // Scan oldest to youngest so later matches override earlier ones:
      // lowest stage wins, and odd overrides even within a stage.
      for (int s = DEPTH - 1; s >= 0; s--) begin
        if (w_even[s].valid && (w_even[s].addr == w_rd_addr[k])) begin
          w_found = 1'b1;
          w_rdy   = spu_pkg::is_ready(s + 1, w_even[s].lat);
          w_win   = w_even[s].data;
        end
        if (w_odd[s].valid && (w_odd[s].addr == w_rd_addr[k])) begin
          w_found = 1'b1;
          w_rdy   = spu_pkg::is_ready(s + 1, w_odd[s].lat);
          w_win   = w_odd[s].data;
        end
      end
      w_hit[k]   = w_found & w_rdy;
      w_fdata[k] = (w_found & w_rdy) ? w_win : '0;
      w_pend[k]  = w_found & ~w_rdy;
    end
  end
`else
  // Without forwarding an operand must wait until its producer has reached
  // stage DEPTH, where the register file write is visible to the next read.
  always_comb begin
    w_hit   = '0;
    w_pend  = '0;
    w_fdata = '{default: '0};
    for (int k = 0; k < NRD; k++) begin
      for (int s = 0; s < DEPTH - 1; s++) begin
        if ((w_even[s].valid && (w_even[s].addr == w_rd_addr[k])) ||
            (w_odd[s].valid  && (w_odd[s].addr  == w_rd_addr[k]))) begin
          w_pend[k] = 1'b1;
        end
      end
    end
  end
`endif

  assign fwd_hit_1  = w_hit[0];
  assign fwd_hit_2  = w_hit[1];
  assign fwd_hit_3  = w_hit[2];
  assign fwd_hit_4  = w_hit[3];
  assign fwd_hit_5  = w_hit[4];
  assign fwd_hit_6  = w_hit[5];
  assign fwd_data_1 = w_fdata[0];
  assign fwd_data_2 = w_fdata[1];
  assign fwd_data_3 = w_fdata[2];
  assign fwd_data_4 = w_fdata[3];
  assign fwd_data_5 = w_fdata[4];
  assign fwd_data_6 = w_fdata[5];
  assign fwd_stall  = |w_pend;

endmodule
`default_nettype wire

// File: doc/wb_fwd_pipe.md
WB_FWD_PIPE -- requirements
Module: wb_fwd_pipe

Interface
REQ-001 Parameter: DEPTH, default 7, number of writeback stages per pipe.
REQ-002 Parameter: ADDR_W, default 7, register address width (128 registers).
REQ-003 Parameter: DATA_W, default 128, register data width.
REQ-004 Port: clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: even_valid / odd_valid  in  1  result injected from even / odd execution pipe this cycle.
REQ-007 Port: even_addr / odd_addr  in  ADDR_W  target register of the injected result.
REQ-008 Port: even_data / odd_data  in  DATA_W  injected result value.
REQ-009 Port: even_lat / odd_lat  in  3  stage at which the result becomes forwardable (0 and 1 both mean stage 1).
REQ-010 Port: flush  in  1  kill all not-yet-committed results.
REQ-011 Port: rd_addr_1..rd_addr_6  in  ADDR_W each  operand addresses, the same six presented to the register file.
REQ-012 Port: fwd_hit_1..fwd_hit_6  out  1 each  forwarded data valid for that operand.
REQ-013 Port: fwd_data_1..fwd_data_6  out  DATA_W each  forwarded value.
REQ-014 Port: fwd_stall  out  1  an operand depends on an in-flight result that is not yet ready.
REQ-015 Port: reg_write_en_1/2, reg_write_addr_1/2, reg_write_data_1/2  out  1/ADDR_W/DATA_W  register-file write ports (1 = even, 2 = odd).

Function
REQ-016 Each pipe is a DEPTH-entry shift register of {valid, addr, data, lat}; an injection is captured into stage 1 on the edge; every entry advances one stage per cycle unconditionally.
REQ-017 Commit: the stage-DEPTH entries drive the reg_write_* outputs combinationally; a result injected at edge N is written by the register file at edge N+DEPTH.
REQ-018 Equal commit addresses: when both stage-DEPTH entries are valid with the same address, reg_write_en_1 is 0 and the odd result alone is written.
REQ-019 Readiness: an entry in stage s is ready when s >= max(lat,1).
REQ-020 Match: operand k matches an entry when the entry is valid and addr equals rd_addr_k.
REQ-021 Priority: the lowest stage index wins; within one stage, odd wins over even, because odd is younger in program order.
REQ-022 Winner ready: fwd_hit_k is 1 and fwd_data_k is the winner's data.
REQ-023 Winner not ready: fwd_hit_k is 0 and fwd_stall is 1.
REQ-024 No match: fwd_hit_k is 0 and fwd_data_k is 0.
REQ-025 fwd_stall is the OR over all six operands; forwarding outputs are combinational from current state.
REQ-026 Flush: valid bits of stages 1..DEPTH-1 are cleared at the edge, and injections in the same cycle are discarded; the stage-DEPTH entries still commit that cycle.

Reset
REQ-027 On rst at the edge, all valid bits are cleared; data, addr and lat registers need not be reset.
REQ-028 After reset, all reg_write_en_*, fwd_hit_* and fwd_stall are 0, and fwd_data_*, reg_write_addr_* and reg_write_data_* read 0.
REQ-029 rst overrides injection and flush; in-flight results are lost and no commit occurs during the reset cycle.

Configuration
REQ-030 Macro WB_FWD_EN defined: forwarding operates per REQ-019..REQ-025.
REQ-031 WB_FWD_EN undefined: fwd_hit_* and fwd_data_* are tied 0, and fwd_stall is 1 whenever any operand matches any valid in-flight entry in stages 1..DEPTH-1; commit behaviour is unchanged.

Structure
REQ-032 Shared package spu_pkg holds ADDR_W, DATA_W, WB_DEPTH and the typedef wb_entry_t {valid, addr, lat, data}.
REQ-033 Sub-module wb_lane implements one pipe's shift register with flush, and is instantiated twice (even, odd); priority muxing lives in the top.

Verification
REQ-034 Even inject addr 5, data 0xAA..AA, lat 2; rd_addr_1=5 -> cycle+1: fwd_stall=1, hit_1=0; cycle+2: hit_1=1 with data 0xAA..AA; cycle+7: reg_write_en_1=1, addr 5.
REQ-035 Even addr 9 data A at cycle 0, even addr 9 data B at cycle 1, both lat 1, rd_addr_2=9 -> from cycle 2, fwd_data_2=B.
REQ-036 Same cycle, even and odd both addr 3, lat 1 -> fwd returns odd data; at commit, reg_write_en_1=0 and reg_write_en_2=1.
REQ-037 Inject addr 7 at cycle 0, flush at cycle 3 -> no commit of addr 7; an entry already at stage DEPTH during the flush cycle still commits.
REQ-038 Inject at cycle 0, rst at cycle 2 -> all outputs 0 from cycle 3; no write ever issued.
REQ-039 Build without WB_FWD_EN: inject addr 4, lat 1; rd_addr_6=4 -> fwd_stall=1 for cycles 1..6, 0 at cycle 7, fwd_hit_6 always 0.
